// File: rtl/ram_port_arbiter_pkg.sv
// Shared core types for the data-RAM port arbiter and the load/store unit:
// word size, access width encoding and the alignment rule.
package ram_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_DATA  = 2'd1,
        OWNER_FETCH = 2'd2
    } owner_t;

    // Only the two low address bits decide alignment; an unknown width encoding is rejected.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb, input write_width_t width);
        logic mis;
        unique case (width)
            write_byte:     mis = 1'b0;
            write_halfword: mis = (addr_lsb == 2'd3);
            write_word:     mis = (addr_lsb != 2'd0);
            default:        mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants while fetch waits.
// sat_o tells the arbiter that fetch must win the next contested cycle.
module ram_port_arbiter_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned    W   = $clog2(LIMIT + 1);
    localparam logic [W-1:0]   MAX = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port data RAM arbiter: data port over fetch with bounded fetch starvation,
// misaligned-access rejection and routing of the one-cycle-latency read word.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_w_data,
    input  write_width_t      d_w_width,
    input  logic              d_w_enable,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_data,
    output logic              d_rsp_err,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_rsp_valid,
    output logic [XLEN-1:0]   i_rsp_data,
    output logic              i_rsp_err,

    output logic [XLEN-1:0]   ram_addr,
    output logic [XLEN-1:0]   ram_w_data,
    output write_width_t      ram_w_width,
    output logic              ram_w_enable,
    input  logic [XLEN-1:0]   ram_r_data
);

    owner_t grant;
    logic   d_misaligned;
    logic   i_misaligned;
    logic   starve_sat;

    owner_t owner_q, owner_d;
    logic   err_q, err_d;
    logic   store_q, store_d;

    assign d_misaligned = is_misaligned(d_addr[1:0], d_w_width);
    assign i_misaligned = is_misaligned(i_addr[1:0], write_word);

    // Gating with reset_n keeps ready and the write strobe low while in reset.
    always_comb begin
        grant = OWNER_NONE;
        if (reset_n) begin
            if (i_req_valid && (starve_sat || !d_req_valid)) begin
                grant = OWNER_FETCH;
            end else if (d_req_valid) begin
                grant = OWNER_DATA;
            end
        end
    end

    assign d_req_ready = (grant == OWNER_DATA);
    assign i_req_ready = (grant == OWNER_FETCH);

    always_comb begin
        ram_addr     = '0;
        ram_w_data   = '0;
        ram_w_width  = write_word;
        ram_w_enable = 1'b0;
        unique case (grant)
            OWNER_DATA: begin
                ram_addr     = d_addr;
                ram_w_data   = d_w_data;
                ram_w_width  = d_w_width;
                ram_w_enable = d_w_enable && !d_misaligned;
            end
            OWNER_FETCH: begin
                ram_addr     = i_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d = grant;
        store_d = (grant == OWNER_DATA) && d_w_enable;
        err_d   = 1'b0;
        if (grant == OWNER_DATA) begin
            err_d = d_misaligned;
        end else if (grant == OWNER_FETCH) begin
            err_d = i_misaligned;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWNER_NONE;
            err_q   <= 1'b0;
            store_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            store_q <= store_d;
        end
    end

    // The RAM word arrives one cycle after the address, so it is steered by the captured owner.
    assign d_rsp_valid = (owner_q == OWNER_DATA);
    assign d_rsp_err   = d_rsp_valid && err_q;
    assign d_rsp_data  = (d_rsp_valid && !err_q && !store_q) ? ram_r_data : '0;

    assign i_rsp_valid = (owner_q == OWNER_FETCH);
    assign i_rsp_err   = i_rsp_valid && err_q;
    assign i_rsp_data  = (i_rsp_valid && !err_q) ? ram_r_data : '0;

    ram_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   ((grant == OWNER_DATA) && i_req_valid),
        .clr_i   ((grant == OWNER_FETCH) || !i_req_valid),
        .sat_o   (starve_sat)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural one-cycle-latency RAM beside it.
// Each vector row is one cycle: inputs plus expected ready/RAM controls and the response of the previous cycle.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;
    localparam logic [31:0] INSN0 = 32'h0000_0013;
    localparam logic [31:0] INSN1 = 32'h0010_0093;
    localparam logic [31:0] INSN2 = 32'h0020_0113;
    localparam int          NVEC  = 28;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              d_req_valid = 1'b0;
    logic              d_req_ready;
    logic [XLEN-1:0]   d_addr = '0;
    logic [XLEN-1:0]   d_w_data = '0;
    write_width_t      d_w_width = write_word;
    logic              d_w_enable = 1'b0;
    logic              d_rsp_valid;
    logic [XLEN-1:0]   d_rsp_data;
    logic              d_rsp_err;
    logic              i_req_valid = 1'b0;
    logic              i_req_ready;
    logic [XLEN-1:0]   i_addr = '0;
    logic              i_rsp_valid;
    logic [XLEN-1:0]   i_rsp_data;
    logic              i_rsp_err;
    logic [XLEN-1:0]   ram_addr;
    logic [XLEN-1:0]   ram_w_data;
    write_width_t      ram_w_width;
    logic              ram_w_enable;
    logic [XLEN-1:0]   ram_r_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_w_data     (d_w_data),
        .d_w_width    (d_w_width),
        .d_w_enable   (d_w_enable),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_addr       (i_addr),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_data   (i_rsp_data),
        .i_rsp_err    (i_rsp_err),
        .ram_addr     (ram_addr),
        .ram_w_data   (ram_w_data),
        .ram_w_width  (ram_w_width),
        .ram_w_enable (ram_w_enable),
        .ram_r_data   (ram_r_data)
    );

    // Behavioural byte-lane RAM: writes land at the edge, read word registered at the same edge.
    logic [XLEN-1:0] mem [0:63];

    always @(posedge clock) begin
        if (ram_w_enable) begin
            case (ram_w_width)
                write_byte:     mem[ram_addr[7:2]][{ram_addr[1:0], 3'b000} +: 8]  <= ram_w_data[7:0];
                write_halfword: mem[ram_addr[7:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_w_data[15:0];
                default:        mem[ram_addr[7:2]] <= ram_w_data;
            endcase
        end
        ram_r_data <= mem[ram_addr[7:2]];
    end

    typedef struct {
        string           name;
        logic            dv;
        logic [31:0]     da;
        logic [31:0]     dd;
        write_width_t    dw;
        logic            dwe;
        logic            iv;
        logic [31:0]     ia;
        logic            e_dr;
        logic            e_ir;
        logic            e_we;
        logic [31:0]     e_ra;
        logic            e_drv;
        logic            e_derr;
        logic [31:0]     e_dd;
        logic            e_irv;
        logic            e_ierr;
        logic [31:0]     e_id;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input string name,
        input logic dv, input logic [31:0] da, input logic [31:0] dd, input write_width_t dw, input logic dwe,
        input logic iv, input logic [31:0] ia,
        input logic e_dr, input logic e_ir, input logic e_we, input logic [31:0] e_ra,
        input logic e_drv, input logic e_derr, input logic [31:0] e_dd,
        input logic e_irv, input logic e_ierr, input logic [31:0] e_id);
        vec_t v;
        v.name = name; v.dv = dv; v.da = da; v.dd = dd; v.dw = dw; v.dwe = dwe;
        v.iv = iv; v.ia = ia;
        v.e_dr = e_dr; v.e_ir = e_ir; v.e_we = e_we; v.e_ra = e_ra;
        v.e_drv = e_drv; v.e_derr = e_derr; v.e_dd = e_dd;
        v.e_irv = e_irv; v.e_ierr = e_ierr; v.e_id = e_id;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        d_req_valid = v.dv;
        d_addr      = v.da;
        d_w_data    = v.dd;
        d_w_width   = v.dw;
        d_w_enable  = v.dwe;
        i_req_valid = v.iv;
        i_addr      = v.ia;
    endtask

    task automatic check_vec(input vec_t v);
        check({v.name, " d_req_ready"},  32'(d_req_ready),  32'(v.e_dr));
        check({v.name, " i_req_ready"},  32'(i_req_ready),  32'(v.e_ir));
        check({v.name, " ram_w_enable"}, 32'(ram_w_enable), 32'(v.e_we));
        check({v.name, " ram_addr"},     ram_addr,          v.e_ra);
        check({v.name, " d_rsp_valid"},  32'(d_rsp_valid),  32'(v.e_drv));
        check({v.name, " d_rsp_err"},    32'(d_rsp_err),    32'(v.e_derr));
        check({v.name, " d_rsp_data"},   d_rsp_data,        v.e_dd);
        check({v.name, " i_rsp_valid"},  32'(i_rsp_valid),  32'(v.e_irv));
        check({v.name, " i_rsp_err"},    32'(i_rsp_err),    32'(v.e_ierr));
        check({v.name, " i_rsp_data"},   i_rsp_data,        v.e_id);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = '0;
        mem[0] = INSN0;
        mem[1] = INSN1;
        mem[2] = INSN2;
        mem[8] = 32'h1122_3344;

        //                name        dv da     dd            dw              dwe iv ia     dr ir we ra       drv derr dd            irv ierr id
        vecs[0]  = mk("idle0",      0, 0,     0,            write_word,     0,  0, 0,     0, 0, 0, 0,      0, 0, 0,             0, 0, 0);
        vecs[1]  = mk("st_w_10",    1, 'h10,  'hDEADBEEF,   write_word,     1,  0, 0,     1, 0, 1, 'h10,   0, 0, 0,             0, 0, 0);
        vecs[2]  = mk("ld_10",      1, 'h10,  0,            write_word,     0,  0, 0,     1, 0, 0, 'h10,   1, 0, 0,             0, 0, 0);
        vecs[3]  = mk("st_h_13",    1, 'h13,  'h5555,       write_halfword, 1,  0, 0,     1, 0, 0, 'h13,   1, 0, 'hDEADBEEF,    0, 0, 0);
        vecs[4]  = mk("ld_10_b",    1, 'h10,  0,            write_word,     0,  0, 0,     1, 0, 0, 'h10,   1, 1, 0,             0, 0, 0);
        vecs[5]  = mk("f_22",       0, 0,     0,            write_word,     0,  1, 'h22,  0, 1, 0, 'h22,   1, 0, 'hDEADBEEF,    0, 0, 0);
        vecs[6]  = mk("st_b_21",    1, 'h21,  'hAB,         write_byte,     1,  0, 0,     1, 0, 1, 'h21,   0, 0, 0,             1, 1, 0);
        vecs[7]  = mk("ld_20",      1, 'h20,  0,            write_word,     0,  0, 0,     1, 0, 0, 'h20,   1, 0, 0,             0, 0, 0);
        vecs[8]  = mk("f_00",       0, 0,     0,            write_word,     0,  1, 'h0,   0, 1, 0, 'h0,    1, 0, 'h1122AB44,    0, 0, 0);
        vecs[9]  = mk("f_04",       0, 0,     0,            write_word,     0,  1, 'h4,   0, 1, 0, 'h4,    0, 0, 0,             1, 0, INSN0);
        vecs[10] = mk("f_08",       0, 0,     0,            write_word,     0,  1, 'h8,   0, 1, 0, 'h8,    0, 0, 0,             1, 0, INSN1);
        vecs[11] = mk("idle11",     0, 0,     0,            write_word,     0,  0, 0,     0, 0, 0, 0,      0, 0, 0,             1, 0, INSN2);
        vecs[12] = mk("idle12",     0, 0,     0,            write_word,     0,  0, 0,     0, 0, 0, 0,      0, 0, 0,             0, 0, 0);
        vecs[13] = mk("both_d1",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   0, 0, 0,             0, 0, 0);
        vecs[14] = mk("both_d2",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   1, 0, 'h1122AB44,    0, 0, 0);
        vecs[15] = mk("both_d3",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   1, 0, 'h1122AB44,    0, 0, 0);
        vecs[16] = mk("both_d4",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   1, 0, 'h1122AB44,    0, 0, 0);
        vecs[17] = mk("both_f5",    1, 'h20,  0,            write_word,     0,  1, 'h0,   0, 1, 0, 'h0,    1, 0, 'h1122AB44,    0, 0, 0);
        vecs[18] = mk("both_d6",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   0, 0, 0,             1, 0, INSN0);
        vecs[19] = mk("both_d7",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   1, 0, 'h1122AB44,    0, 0, 0);
        vecs[20] = mk("both_d8",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   1, 0, 'h1122AB44,    0, 0, 0);
        vecs[21] = mk("both_d9",    1, 'h20,  0,            write_word,     0,  1, 'h0,   1, 0, 0, 'h20,   1, 0, 'h1122AB44,    0, 0, 0);
        vecs[22] = mk("both_f10",   1, 'h20,  0,            write_word,     0,  1, 'h0,   0, 1, 0, 'h0,    1, 0, 'h1122AB44,    0, 0, 0);
        vecs[23] = mk("idle23",     0, 0,     0,            write_word,     0,  0, 0,     0, 0, 0, 0,      0, 0, 0,             1, 0, INSN0);
        vecs[24] = mk("st_h_12",    1, 'h12,  'h7777,       write_halfword, 1,  0, 0,     1, 0, 1, 'h12,   0, 0, 0,             0, 0, 0);
        vecs[25] = mk("ld_w_11",    1, 'h11,  0,            write_word,     0,  0, 0,     1, 0, 0, 'h11,   1, 0, 0,             0, 0, 0);
        vecs[26] = mk("ld_10_c",    1, 'h10,  0,            write_word,     0,  0, 0,     1, 0, 0, 'h10,   1, 1, 0,             0, 0, 0);
        vecs[27] = mk("idle27",     0, 0,     0,            write_word,     0,  0, 0,     0, 0, 0, 0,      1, 0, 'h7777BEEF,    0, 0, 0);

        // In reset with both requesters asserting a store/fetch: no ready, no write, quiet responses.
        d_req_valid = 1'b1; d_addr = 'h10; d_w_enable = 1'b1; i_req_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst d_req_ready",  32'(d_req_ready),  0);
        check("rst i_req_ready",  32'(i_req_ready),  0);
        check("rst ram_w_enable", 32'(ram_w_enable), 0);
        check("rst d_rsp_valid",  32'(d_rsp_valid),  0);
        check("rst i_rsp_valid",  32'(i_rsp_valid),  0);
        check("rst d_rsp_err",    32'(d_rsp_err),    0);
        check("rst i_rsp_err",    32'(i_rsp_err),    0);
        check("rst d_rsp_data",   d_rsp_data,        0);
        check("rst i_rsp_data",   i_rsp_data,        0);

        @(negedge clock);
        d_req_valid = 1'b0; d_addr = '0; d_w_enable = 1'b0; i_req_valid = 1'b0;
        reset_n = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            @(negedge clock);
            apply(vecs[k]);
            #1;
            check_vec(vecs[k]);
        end

        // Reset dropped in the cycle after a load is accepted: the pending response is discarded.
        @(negedge clock);
        d_req_valid = 1'b1; d_addr = 'h20; d_w_width = write_word; d_w_enable = 1'b0;
        #1;
        check("mid ld accepted", 32'(d_req_ready), 1);
        @(negedge clock);
        reset_n = 1'b0;
        d_w_enable = 1'b1;
        #1;
        check("mid d_rsp_valid",  32'(d_rsp_valid),  0);
        check("mid d_rsp_data",   d_rsp_data,        0);
        check("mid d_rsp_err",    32'(d_rsp_err),    0);
        check("mid i_rsp_valid",  32'(i_rsp_valid),  0);
        check("mid d_req_ready",  32'(d_req_ready),  0);
        check("mid ram_w_enable", 32'(ram_w_enable), 0);
        @(negedge clock);
        reset_n = 1'b1;
        d_req_valid = 1'b0; d_w_enable = 1'b0;
        #1;
        check("post d_rsp_valid", 32'(d_rsp_valid), 0);
        @(negedge clock);
        #1;
        check("post idle d_rsp_valid", 32'(d_rsp_valid), 0);
        @(negedge clock);
        d_req_valid = 1'b1; d_addr = 'h20;
        #1;
        check("post ld ready", 32'(d_req_ready), 1);
        @(negedge clock);
        d_req_valid = 1'b0;
        #1;
        check("post ld rsp_valid", 32'(d_rsp_valid), 1);
        check("post ld rsp_data",  d_rsp_data,       'h1122AB44);
        check("post ld rsp_err",   32'(d_rsp_err),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
